// File: rtl/cs_sym_serializer_pkg.sv
// Shared coding definitions used by the encoder, serializer and decoder.
package cs_pkg;
  localparam int CS_K = 5;
  localparam int CS_L = 11;

  typedef logic [CS_L-2:0] cs_sym_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } cs_state_e;

  // Index width for a K-entry block, never narrower than one bit.
  function automatic int cs_idx_w(input int k);
    return (k <= 2) ? 1 : $clog2(k);
  endfunction
endpackage

// File: rtl/cs_sym_serializer_if.sv
// Block-in / symbol-out stream bundle of the serializer.
interface cs_sym_serializer_if #(
    parameter int K = 5,
    parameter int L = 11
);
    localparam int IW = cs_pkg::cs_idx_w(K);

    logic                  in_valid;
    logic                  in_ready;
    logic [K-1:0][L-2:0]   in_data;
    logic [K-1:0]          in_mask;
    logic                  out_valid;
    logic                  out_ready;
    logic [L-2:0]          out_data;
    logic [IW-1:0]         out_idx;
    logic                  out_last;
    logic [15:0]           drop_cnt;

    modport master (
        output in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, drop_cnt
    );
endinterface

// File: rtl/cs_sym_serializer_next_set.sv
// Finds the lowest set mask bit above idx_i (or at idx_i when incl_i); none_o if there is none.
module cs_next_set
    import cs_pkg::*;
#(
    parameter int K  = 5,
    parameter int IW = cs_idx_w(K)
) (
    input  logic [K-1:0]  mask_i,
    input  logic [IW-1:0] idx_i,
    input  logic          incl_i,
    output logic [IW-1:0] nxt_o,
    output logic          none_o
);
    always_comb begin
        nxt_o  = '0;
        none_o = 1'b1;
        // Descending scan so the lowest qualifying bit wins.
        for (int i = K - 1; i >= 0; i--) begin
            if (mask_i[i] && ((i > int'(idx_i)) || (incl_i && (i == int'(idx_i))))) begin
                nxt_o  = IW'(i);
                none_o = 1'b0;
            end
        end
    end
endmodule

// File: rtl/cs_sym_serializer.sv
// Serializes a K-symbol coded block into one symbol per beat, skipping erased symbols.
module cs_sym_serializer
    import cs_pkg::*;
#(
    parameter int K = 5,
    parameter int L = 11
) (
    input logic                aclk,
    input logic                aresetn,
    cs_sym_serializer_if.slave bus
);
    localparam int IW = cs_idx_w(K);

    cs_state_e           state_q;
    logic [K-1:0][L-2:0] buf_q;
    logic [K-1:0]        mask_q;
    logic [IW-1:0]       ptr_q;
    logic [15:0]         drop_q, drop_d;

    logic [IW-1:0] low_idx, nxt_idx;
    logic          low_none, last;
    logic          send, in_ready, accept, beat_done;

    cs_next_set #(.K(K), .IW(IW)) u_low (
        .mask_i (bus.in_mask),
        .idx_i  (IW'(0)),
        .incl_i (1'b1),
        .nxt_o  (low_idx),
        .none_o (low_none)
    );

    cs_next_set #(.K(K), .IW(IW)) u_nxt (
        .mask_i (mask_q),
        .idx_i  (ptr_q),
        .incl_i (1'b0),
        .nxt_o  (nxt_idx),
        .none_o (last)
    );

    // Outputs are forced low while reset is held, independent of register state.
    assign send      = aresetn && (state_q == ST_SEND);
    assign beat_done = send && bus.out_ready;
    assign in_ready  = aresetn && ((state_q == ST_IDLE) || (last && bus.out_ready));
    assign accept    = bus.in_valid && in_ready;
    assign drop_d    = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = send;
    assign bus.out_data  = send ? buf_q[ptr_q] : '0;
    assign bus.out_idx   = send ? ptr_q : '0;
    assign bus.out_last  = send && last;
    assign bus.drop_cnt  = aresetn ? drop_q : '0;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            ptr_q   <= '0;
            drop_q  <= '0;
        end else begin
            if (beat_done && !last) ptr_q <= nxt_idx;
            if (accept) begin
                if (low_none) begin
                    drop_q  <= drop_d;
                    state_q <= ST_IDLE;
                end else begin
                    mask_q  <= bus.in_mask;
                    ptr_q   <= low_idx;
                    state_q <= ST_SEND;
                end
            end else if (beat_done && last) begin
                state_q <= ST_IDLE;
            end
        end
    end

    // Symbol storage carries no reset; it is only read once the mask marks it valid.
    always_ff @(posedge aclk) begin
        if (accept && !low_none) buf_q <= bus.in_data;
    end
endmodule
